// File: rtl/dus_hir_kernel.sv
// dus_hir_kernel
//   Down-up-sample image kernel. A start pulse walks a ROWS x COLS image held
//   in an external read memory. Each output pixel (i,j) is written to an
//   external write memory as img[i & ~1][j & ~1]. Each 2x2 block therefore
//   repeats its top-left input pixel. Throughput is one pixel per clock.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   t                  : start pulse, honoured only while idle
//   img_p0_addr_data   : read address (decimated pixel index)
//   img_p0_addr_en     : read address valid (same as img_p0_rd_en)
//   img_p0_rd_en       : read strobe
//   img_p0_rd_data     : read data, valid one cycle after the read strobe
//   dus_p0_addr_data   : write address (undecimated pixel index)
//   dus_p0_addr_en     : write address valid (same as dus_p0_wr_en)
//   dus_p0_wr_data     : write data (read data passed through, 0 when idle)
//   dus_p0_wr_en       : write strobe
module dus_hir_kernel #(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  output logic [ADDR_W-1:0] img_p0_addr_data,
  output logic              img_p0_addr_en,
  output logic              img_p0_rd_en,
  input  logic [WIDTH-1:0]  img_p0_rd_data,
  output logic [ADDR_W-1:0] dus_p0_addr_data,
  output logic              dus_p0_addr_en,
  output logic [WIDTH-1:0]  dus_p0_wr_data,
  output logic              dus_p0_wr_en
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(ROWS * COLS - 1);
  // Clearing bit 0 of the column and bit 0 of the row in the linear index
  // gives the top-left pixel of the enclosing 2x2 block.
  localparam logic [ADDR_W-1:0] DEC_MASK = ~(ADDR_W'(COLS) | ADDR_W'(1));

  function automatic logic [ADDR_W-1:0] decim_addr(input logic [ADDR_W-1:0] pix);
    return pix & DEC_MASK;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] pix_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_p0     <= '0;
      rd_addr_p0 <= '0;
      vld_p0     <= 1'b0;
      wr_addr_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      // p0 -> p1: the write address trails the read by one cycle, matching
      // the memory's one-cycle read latency.
      vld_p1     <= vld_p0;
      wr_addr_p1 <= vld_p0 ? pix_p0 : '0;

      // p0: read issue sequencer
      case (state)
        IDLE: begin
          if (t) begin
            state      <= RUN;
            vld_p0     <= 1'b1;
            pix_p0     <= '0;
            rd_addr_p0 <= '0;
          end
        end
        RUN: begin
          if (pix_p0 == LAST_PIX) begin
            state      <= DRAIN;
            vld_p0     <= 1'b0;
            pix_p0     <= '0;
            rd_addr_p0 <= '0;
          end else begin
            pix_p0     <= pix_p0 + ADDR_W'(1);
            rd_addr_p0 <= decim_addr(pix_p0 + ADDR_W'(1));
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign img_p0_addr_data = rd_addr_p0;
  assign img_p0_addr_en   = vld_p0;
  assign img_p0_rd_en     = vld_p0;

  // p1: write port; the memory's registered read data is forwarded unchanged
  // and forced to 0 outside write cycles.
  assign dus_p0_addr_data = wr_addr_p1;
  assign dus_p0_addr_en   = vld_p1;
  assign dus_p0_wr_en     = vld_p1;
  assign dus_p0_wr_data   = vld_p1 ? img_p0_rd_data : '0;

endmodule

// File: tb/tb_dus_hir_kernel.sv
module tb_dus_hir_kernel;
  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int N      = ROWS * COLS;
  localparam logic [31:0] SENT = 32'hA5A5A5A5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              t   = 1'b0;
  logic [ADDR_W-1:0] img_p0_addr_data;
  logic              img_p0_addr_en;
  logic              img_p0_rd_en;
  logic [WIDTH-1:0]  img_p0_rd_data;
  logic [ADDR_W-1:0] dus_p0_addr_data;
  logic              dus_p0_addr_en;
  logic [WIDTH-1:0]  dus_p0_wr_data;
  logic              dus_p0_wr_en;

  dus_hir_kernel #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .t                (t),
    .img_p0_addr_data (img_p0_addr_data),
    .img_p0_addr_en   (img_p0_addr_en),
    .img_p0_rd_en     (img_p0_rd_en),
    .img_p0_rd_data   (img_p0_rd_data),
    .dus_p0_addr_data (dus_p0_addr_data),
    .dus_p0_addr_en   (dus_p0_addr_en),
    .dus_p0_wr_data   (dus_p0_wr_data),
    .dus_p0_wr_en     (dus_p0_wr_en)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] img     [N];
  logic [WIDTH-1:0] dus_mem [N];
  logic [WIDTH-1:0] exp_dus [N];
  int  mn       = 0;
  int  wr_cnt   = 0;
  int  rd_cnt   = 0;
  int  checks   = 0;
  int  errors   = 0;
  bit  chk_en   = 1'b0;
  bit  fill_now = 1'b0;

  // Linear index of the top-left pixel of the 2x2 block holding pixel p.
  function automatic int dec_pix(input int p);
    int i;
    int j;
    i = p / COLS;
    j = p % COLS;
    return (i - (i % 2)) * COLS + (j - (j % 2));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // External memories: registered read port, write on the strobe edge.
  always @(posedge clk) begin
    if (img_p0_rd_en) begin
      img_p0_rd_data <= img[img_p0_addr_data];
      rd_cnt         <= rd_cnt + 1;
    end
    if (fill_now) begin
      for (int a = 0; a < N; a++) dus_mem[a] <= SENT;
    end else if (dus_p0_wr_en) begin
      dus_mem[dus_p0_addr_data] <= dus_p0_wr_data;
    end
    if (dus_p0_wr_en) wr_cnt <= wr_cnt + 1;
  end

  // Reference model: mn is the cycle number within a run (0 = idle);
  // cycle n reads pixel n-1, cycle n+1 writes it.
  always @(posedge clk) begin
    if (fill_now) begin
      for (int a = 0; a < N; a++) exp_dus[a] <= SENT;
    end else if (mn >= 2 && mn <= N + 1) begin
      exp_dus[mn-2] <= img[dec_pix(mn - 2)];
    end
    if (rst)              mn <= 0;
    else if (mn == 0)     mn <= t ? 1 : 0;
    else if (mn == N + 1) mn <= 0;
    else                  mn <= mn + 1;
  end

  always @(negedge clk) begin
    logic        er;
    logic        ew;
    logic [31:0] ear;
    logic [31:0] eaw;
    logic [31:0] ed;
    if (chk_en) begin
      er  = (mn >= 1 && mn <= N);
      ew  = (mn >= 2 && mn <= N + 1);
      ear = er ? 32'(dec_pix(mn - 1)) : 32'd0;
      eaw = ew ? 32'(mn - 2) : 32'd0;
      ed  = ew ? img[dec_pix(mn - 2)] : 32'd0;
      check("rd_en",      {31'd0, img_p0_rd_en},   {31'd0, er});
      check("rd_addr_en", {31'd0, img_p0_addr_en}, {31'd0, er});
      check("rd_addr",    32'(img_p0_addr_data),   ear);
      check("wr_en",      {31'd0, dus_p0_wr_en},   {31'd0, ew});
      check("wr_addr_en", {31'd0, dus_p0_addr_en}, {31'd0, ew});
      check("wr_addr",    32'(dus_p0_addr_data),   eaw);
      check("wr_data",    dus_p0_wr_data,          ed);
    end
  end

  task automatic fill_sentinel();
    fill_now = 1'b1;
    @(posedge clk);
    #1 fill_now = 1'b0;
  endtask

  // Starts a run from idle and advances to the first idle cycle afterwards
  // (or to the cycle after an abort when rst_at > 0).
  task automatic run(input bit pin, input int retrig_at, input int rst_at);
    int w0;
    int r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    t  = 1'b1;
    @(posedge clk);
    #1 t = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      t = (c == retrig_at);
      if (c == rst_at) rst = 1'b1;
      if (pin && c == 1) begin
        @(negedge clk);
        check("first_rd_en",   {31'd0, img_p0_rd_en}, 32'd1);
        check("first_rd_addr", 32'(img_p0_addr_data), 32'd0);
        check("first_wr_idle", {31'd0, dus_p0_wr_en}, 32'd0);
      end
      if (pin && c == 2) begin
        @(negedge clk);
        check("first_wr_en",   {31'd0, dus_p0_wr_en}, 32'd1);
        check("first_wr_addr", 32'(dus_p0_addr_data), 32'd0);
        check("first_wr_data", dus_p0_wr_data, img[0]);
      end
      @(posedge clk);
      #1;
      t   = 1'b0;
      rst = 1'b0;
      if (c == rst_at) break;
    end
    check("wr_count", 32'(wr_cnt - w0), (rst_at > 0) ? 32'(rst_at - 1) : 32'(N));
    check("rd_count", 32'(rd_cnt - r0), (rst_at > 0) ? 32'(rst_at) : 32'(N));
  endtask

  task automatic compare_image(input string name);
    for (int a = 0; a < N; a++) check(name, dus_mem[a], exp_dus[a]);
  endtask

  task automatic ramp_literals();
    check("dus0",    dus_mem[0],    32'd0);
    check("dus1",    dus_mem[1],    32'd0);
    check("dus2",    dus_mem[2],    32'd2);
    check("dus32",   dus_mem[32],   32'd0);
    check("dus33",   dus_mem[33],   32'd0);
    check("dus34",   dus_mem[34],   32'd2);
    check("dus1023", dus_mem[1023], 32'd990);
  endtask

  initial begin
    int nz;
    int w0;
    for (int a = 0; a < N; a++) img[a] = 32'(a);
    rst      = 1'b1;
    fill_now = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    fill_now  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: model expects everything at zero.
    repeat (2000) @(posedge clk);
    #1;

    // Ramp image, single pulse with strobe timing pins.
    run(1'b1, 0, 0);
    check("model_1023", exp_dus[1023], 32'd990);
    ramp_literals();
    compare_image("ramp_img");

    // Re-trigger at cycle 500 ignored, then back-to-back second pass.
    fill_sentinel();
    run(1'b0, 500, 0);
    ramp_literals();
    compare_image("retrig_img");
    fill_sentinel();
    run(1'b0, 0, 0);
    ramp_literals();
    compare_image("second_img");

    // Reset at cycle 300: pixels 0..298 written, the rest untouched.
    for (int a = 0; a < N; a++) img[a] = 32'(a) + 32'h10000;
    fill_sentinel();
    run(1'b0, 0, 300);
    w0 = wr_cnt;
    repeat (50) @(posedge clk);
    #1;
    check("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("abort_dus0",   dus_mem[0],   32'h10000);
    check("abort_dus298", dus_mem[298], 32'h1010A);
    check("abort_dus299", dus_mem[299], SENT);
    compare_image("abort_img");

    // Checkerboard: odd words all ones, even-column decimation yields 0.
    for (int a = 0; a < N; a++) img[a] = (a % 2 == 1) ? 32'hFFFFFFFF : 32'h0;
    fill_sentinel();
    run(1'b0, 0, 0);
    nz = 0;
    for (int a = 0; a < N; a++) if (dus_mem[a] != 32'h0) nz++;
    check("checker_nonzero", 32'(nz), 32'd0);
    compare_image("checker_img");

    repeat (5) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
